// File: rtl/rs232_rx_axis.sv
// RS-232 receiver with an AXI-stream output FIFO and RTSn flow control.
// The line is synchronized, framed by a half/full-bit baud counter and an
// FSM, and good characters are pushed into a first-word-fall-through FIFO.
// Optional build macro: RS232_RX_MAJORITY_EN -- each bit is the 2-of-3
// majority of the samples around the bit centre; push and flags then land
// exactly one clock later than with the single centre sample.
module rs232_rx_axis #(
  parameter real CLOCK_FREQ   = 133000000.0,
  parameter real BAUD_RATE    = 115200.0,
  parameter int  DATA_BITS    = 8,
  parameter int  PARITY       = 0,
  parameter int  BUFFER_LOG2  = 4,
  parameter int  AFULL_MARGIN = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 rxd_pin,
  output logic                 rtsn_pin,
  output logic [DATA_BITS-1:0] odata,
  output logic                 ovalid,
  input  logic                 oready,
  output logic                 overflow,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int DEPTH     = 1 << BUFFER_LOG2;
  localparam int PTR_W     = BUFFER_LOG2;
  localparam int BAUD_FULL = int'(CLOCK_FREQ / BAUD_RATE);
  localparam int BAUD_HALF = BAUD_FULL / 2;
  localparam int CNT_W     = $clog2(BAUD_FULL + 1);
`ifdef RS232_RX_MAJORITY_EN
  // One extra clock so the decision is taken at centre+1.
  localparam int HOLD      = BAUD_HALF;
`else
  localparam int HOLD      = BAUD_HALF - 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 rx_meta, rx_sync;
  logic                 tick;
  logic                 bit_val;
  logic                 par_ok;
  logic                 is_break;
  logic                 push_req;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic [PTR_W:0]       free_slots;
  logic                 full;
  logic                 push, pop;

  // Two-flop synchronizer for the asynchronous line; idles at mark (1).
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd_pin;
      rx_sync <= rx_meta;
    end
  end

`ifdef RS232_RX_MAJORITY_EN
  logic rx_d1, rx_d2;

  // Keep the two previous synchronized samples for the 2-of-3 vote.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_sync;
      rx_d2 <= rx_d1;
    end
  end

  assign bit_val = (rx_sync & rx_d1) | (rx_sync & rx_d2) | (rx_d1 & rx_d2);
`else
  assign bit_val = rx_sync;
`endif

  assign tick = (cnt == '0);

  // Break = all data and parity bits low followed by a low stop bit.
  assign is_break = (shreg == '0) && ((PARITY == 0) || !par_bit);

  // Decide whether the completed character is good and should be pushed.
  // NOTE: every signal of a combinational block gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    par_ok   = 1'b1;
    push_req = 1'b0;
    if (PARITY == 1) par_ok = ^{shreg, par_bit};
    if (PARITY == 2) par_ok = ~^{shreg, par_bit};
    if (state == S_STOP && tick && bit_val && par_ok) push_req = 1'b1;
  end

  // Framing FSM with baud counter, error pulses and RTSn flow control.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= CNT_W'(HOLD);
      bit_idx    <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      rtsn_pin   <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      if (state == S_IDLE || state == S_BREAK) cnt <= CNT_W'(HOLD);
      else if (tick)                           cnt <= CNT_W'(BAUD_FULL - 1);
      else                                     cnt <= cnt - 1'b1;

      case (state)
        S_IDLE: begin
          rtsn_pin <= (free_slots <= (PTR_W+1)'(AFULL_MARGIN));
          bit_idx  <= '0;
          if (!rx_sync) state <= S_START;
        end
        S_START: begin
          if (tick) state <= bit_val ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (tick) begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'(DATA_BITS - 1))
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (tick) state <= S_STOP;
        end
        S_STOP: begin
          if (tick) begin
            if (!par_ok) parity_err <= 1'b1;
            if (bit_val) begin
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= is_break ? S_BREAK : S_IDLE;
            end
          end
        end
        S_BREAK: begin
          if (rx_sync) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Character data path: LSB arrives first, so shift in from the top.
  // NOTE: the shift register and FIFO storage carry no reset; their contents
  // are only observed once qualified by the FSM or by ovalid.
  always_ff @(posedge clock) begin
    if (state == S_DATA && tick)   shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
    if (state == S_PARITY && tick) par_bit <= bit_val;
  end

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign free_slots = (PTR_W+1)'(DEPTH) - count;
  assign ovalid     = (count != '0);
  assign odata      = mem[rd_ptr];
  assign pop        = ovalid && oready;
  // A full FIFO still accepts a push when the same cycle pops.
  assign push       = push_req && (!full || pop);

  // FIFO storage write port.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rs232_rx_axis.sv
// Bench for rs232_rx_axis: two instances (no parity, even parity) driven by
// directed and random frames; a queue-based reference model predicts the
// delivered characters and the number of error pulses.
module tb_rs232_rx_axis;

  localparam int FULL  = 10;
  localparam int HALF  = FULL / 2;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd0, rxd1;
  logic       oready0, oready1;
  logic [7:0] odata0, odata1;
  logic       ovalid0, ovalid1;
  logic       rtsn0, rtsn1;
  logic       ovf0, ovf1;
  logic       fe0, fe1, pe0, pe1;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         fe_cnt[2] = '{0, 0};
  int         pe_cnt[2] = '{0, 0};
  int         fe_exp[2] = '{0, 0};
  int         pe_exp[2] = '{0, 0};
  int         last_rise0 = 0;
  logic       ovalid0_q = 1'b0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rs232_rx_axis #(
    .CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .DATA_BITS(8), .PARITY(0),
    .BUFFER_LOG2(3), .AFULL_MARGIN(4)
  ) dut0 (
    .clock(clk), .resetn(rst_n), .rxd_pin(rxd0), .rtsn_pin(rtsn0),
    .odata(odata0), .ovalid(ovalid0), .oready(oready0), .overflow(ovf0),
    .frame_err(fe0), .parity_err(pe0)
  );

  rs232_rx_axis #(
    .CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .DATA_BITS(8), .PARITY(2),
    .BUFFER_LOG2(3), .AFULL_MARGIN(4)
  ) dut1 (
    .clock(clk), .resetn(rst_n), .rxd_pin(rxd1), .rtsn_pin(rtsn1),
    .odata(odata1), .ovalid(ovalid1), .oready(oready1), .overflow(ovf1),
    .frame_err(fe1), .parity_err(pe1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_vec++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fe0) fe_cnt[0]++;
      if (fe1) fe_cnt[1]++;
      if (pe0) pe_cnt[0]++;
      if (pe1) pe_cnt[1]++;
      if (ovalid0 && !ovalid0_q) last_rise0 = cyc;
      if (ovalid0 && oready0) begin
        check("beat0_expected", 32'(exp0.size() != 0), 32'd1);
        if (exp0.size() != 0) check("odata0", 32'(odata0), 32'(exp0.pop_front()));
      end
      if (ovalid1 && oready1) begin
        check("beat1_expected", 32'(exp1.size() != 0), 32'd1);
        if (exp1.size() != 0) check("odata1", 32'(odata1), 32'(exp1.pop_front()));
      end
    end
    ovalid0_q = ovalid0;
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after a rising edge.
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int ch, input logic b);
    if (ch == 0) rxd0 = b;
    else         rxd1 = b;
  endtask

  // Reference model: a character is delivered only with a high stop bit and
  // correct even parity; a low stop bit and a bad parity bit each pulse once.
  task automatic expect_frame(input int ch, input logic [7:0] d, input bit has_par,
                              input bit par, input bit stop);
    bit par_bad;
    par_bad = has_par && (par != (^d));
    if (!stop)  fe_exp[ch]++;
    if (par_bad) pe_exp[ch]++;
    if (stop && !par_bad) begin
      if (ch == 0) exp0.push_back(d);
      else         exp1.push_back(d);
    end
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop, then 2 idle bits.
  task automatic send_frame(input int ch, input logic [7:0] d, input bit has_par,
                            input bit par, input bit stop);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(par);
    bits.push_back(stop);
    foreach (bits[i]) begin
      set_line(ch, bits[i]);
      tick_n(FULL);
    end
    set_line(ch, 1'b1);
    tick_n(2 * FULL);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && (exp0.size() != 0 || exp1.size() != 0); i++) tick_n(1);
    check({tag, "_pending"}, 32'(exp0.size() + exp1.size()), 32'd0);
  endtask

  initial begin
    int t0;
    logic [7:0] d;
    bit par, stop;

    rst_n = 1'b0; rxd0 = 1'b1; rxd1 = 1'b1; oready0 = 1'b1; oready1 = 1'b1;
    tick_n(3);
    check("rst_ovalid0", 32'(ovalid0), 32'd0);
    check("rst_ovalid1", 32'(ovalid1), 32'd0);
    check("rst_flags0", {29'd0, ovf0, fe0, pe0}, 32'd0);
    check("rst_flags1", {29'd0, ovf1, fe1, pe1}, 32'd0);
    check("rst_rtsn", {30'd0, rtsn0, rtsn1}, 32'd0);
    rst_n = 1'b1;
    tick_n(2 * FULL);

    // 0xA5: ovalid rises 2 sync + half bit + 9 bits + 1 clocks after the edge.
    t0 = cyc;
    expect_frame(0, 8'hA5, 0, 0, 1);
    send_frame(0, 8'hA5, 0, 0, 1);
    wait_drain("a5");
    check_range("a5_latency", last_rise0 - t0, 2 + HALF + 9 * FULL + 1 - 1,
                2 + HALF + 9 * FULL + 1 + 1);
    check("a5_frame_err", 32'(fe_cnt[0]), 32'(fe_exp[0]));

    // 3-clock glitch is a false start; the next character must still arrive.
    rxd0 = 1'b0;
    tick_n(3);
    rxd0 = 1'b1;
    tick_n(3 * FULL);
    check("glitch_fe", 32'(fe_cnt[0]), 32'(fe_exp[0]));
    check("glitch_pe", 32'(pe_cnt[0]), 32'(pe_exp[0]));
    check("glitch_nopush", 32'(ovalid0), 32'd0);
    expect_frame(0, 8'h96, 0, 0, 1);
    send_frame(0, 8'h96, 0, 0, 1);
    wait_drain("after_glitch");

    // Even parity: 0x03 with parity 1 is bad, with parity 0 is good.
    expect_frame(1, 8'h03, 1, 1, 1);
    send_frame(1, 8'h03, 1, 1, 1);
    check("par_bad_pe", 32'(pe_cnt[1]), 32'(pe_exp[1]));
    check("par_bad_nopush", 32'(ovalid1), 32'd0);
    expect_frame(1, 8'h03, 1, 0, 1);
    send_frame(1, 8'h03, 1, 0, 1);
    wait_drain("par_good");
    check("par_good_pe", 32'(pe_cnt[1]), 32'(pe_exp[1]));

    // Break: 30 bit times low gives exactly one frame error.
    rxd0 = 1'b0;
    tick_n(30 * FULL);
    rxd0 = 1'b1;
    fe_exp[0]++;
    tick_n(3 * FULL);
    check("break_fe", 32'(fe_cnt[0]), 32'(fe_exp[0]));
    check("break_nopush", 32'(ovalid0), 32'd0);
    expect_frame(0, 8'h55, 0, 0, 1);
    send_frame(0, 8'h55, 0, 0, 1);
    wait_drain("after_break");

    // Back-pressure: 9 characters into an 8-deep FIFO.
    oready0 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) expect_frame(0, 8'(i), 0, 0, 1);
      send_frame(0, 8'(i), 0, 0, 1);
      check($sformatf("rtsn_after_%0d", i), 32'(rtsn0),
            32'((DEPTH - ((i + 1 < DEPTH) ? i + 1 : DEPTH)) <= 4));
      check($sformatf("ovf_after_%0d", i), 32'(ovf0), 32'(i == 8));
    end
    check("head_stable", 32'(odata0), 32'h00);
    oready0 = 1'b1;
    wait_drain("overflow_drain");
    tick_n(2);
    check("rtsn_drained", 32'(rtsn0), 32'd0);

    // Reset in the middle of DATA, then a clean 0x3C.
    rxd0 = 1'b0;
    tick_n(FULL);
    for (int i = 0; i < 3; i++) begin
      rxd0 = 1'(8'h3C >> i);
      tick_n(FULL);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_ovalid", 32'(ovalid0), 32'd0);
    check("midrst_flags", {29'd0, ovf0, fe0, pe0}, 32'd0);
    check("midrst_rtsn", 32'(rtsn0), 32'd0);
    rxd0 = 1'b1;
    tick_n(5);
    rst_n = 1'b1;
    tick_n(2 * FULL);
    expect_frame(0, 8'h3C, 0, 0, 1);
    send_frame(0, 8'h3C, 0, 0, 1);
    wait_drain("after_reset");

    // Random traffic, no parity, with intermittent back-pressure.
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      oready0 = (i % 3 == 0) ? 1'b1 : 1'($urandom);
      expect_frame(0, d, 0, 0, stop);
      send_frame(0, d, 0, 0, stop);
    end
    oready0 = 1'b1;
    wait_drain("rand0");

    // Random traffic, even parity, with parity and framing faults.
    for (int i = 0; i < 16; i++) begin
      d    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      par  = (^d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      expect_frame(1, d, 1, par, stop);
      send_frame(1, d, 1, par, stop);
    end
    wait_drain("rand1");

    check("total_fe0", 32'(fe_cnt[0]), 32'(fe_exp[0]));
    check("total_pe0", 32'(pe_cnt[0]), 32'(pe_exp[0]));
    check("total_fe1", 32'(fe_cnt[1]), 32'(fe_exp[1]));
    check("total_pe1", 32'(pe_cnt[1]), 32'(pe_exp[1]));
    check("final_ovf1", 32'(ovf1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
